uart_project: RTL and testbench

//  Full-duplex 8N1 UART (1 start bit, 8 data bits LSB first, 1 stop bit, no parity).
//  TX serialises a byte on a one-cycle load strobe; RX deserialises the serial input and flags framing errors.
//  One of two baud rates is selected by a pin. Top-level serial interface block between the system bus and the pins.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_project.sv | 170 +++++++++++++++++
 tb/tb_uart_project.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, widths and rate helpers for the 8N1 UART
package uart_pkg;
   localparam int DATA_BITS       = 8;
   localparam int DEF_CLK_FREQ_HZ = 10_000_000;
   localparam int DEF_BAUD_0      = 9600;
   localparam int DEF_BAUD_1      = 19200;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

   // Timers hold terminal counts (period - 1), so the largest period itself never needs storing.
   function automatic int cnt_width(input int cpb_a, input int cpb_b);
      return $clog2((cpb_a > cpb_b) ? cpb_a : cpb_b);
   endfunction

   localparam int CNT_W = cnt_width(clks_per_bit(DEF_CLK_FREQ_HZ, DEF_BAUD_0),
                                    clks_per_bit(DEF_CLK_FREQ_HZ, DEF_BAUD_1));
endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - reloadable bit-period down-counter, one per direction
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CNT_W_P = CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               load,
   input  logic [CNT_W_P-1:0] load_val,
   output logic               tick
);
   logic [CNT_W_P-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W_P'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tick = en && (cnt_q == '0);
endmodule

// File: rtl/uart_project.sv
// rtl/uart_project.sv - full-duplex 8N1 UART with pin-selected baud rate
// Optional: define UART_RX_SYNC_EN to put a 2-flop synchroniser on RxDataIn.
module uart_project
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
   parameter int BAUD_0      = DEF_BAUD_0,
   parameter int BAUD_1      = DEF_BAUD_1
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       BaudRate,
   input  logic       TxDataLoad,
   input  logic [7:0] TxDataIn,
   output logic       TxDataOut,
   input  logic       RxDataIn,
   output logic [7:0] RxDataOut,
   output logic       TxDone,
   output logic       RxDone,
   output logic       RxError
);
   localparam int CPB0 = clks_per_bit(CLK_FREQ_HZ, BAUD_0);
   localparam int CPB1 = clks_per_bit(CLK_FREQ_HZ, BAUD_1);
   localparam int CW   = cnt_width(CPB0, CPB1);
   localparam logic [CW-1:0] FULL0 = CW'(CPB0 - 1);
   localparam logic [CW-1:0] FULL1 = CW'(CPB1 - 1);
   localparam logic [CW-1:0] HALF0 = CW'(CPB0 / 2 - 1);
   localparam logic [CW-1:0] HALF1 = CW'(CPB1 / 2 - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   tx_state_t            tx_state_q, tx_state_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic [2:0]           tx_bit_q, tx_bit_d;
   logic                 tx_baud_q, tx_baud_d, tx_out_q, tx_out_d, tx_done_q, tx_done_d;
   logic                 tx_tick, tx_load;
   logic [CW-1:0]        tx_load_val;

   rx_state_t            rx_state_q, rx_state_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
   logic [2:0]           rx_bit_q, rx_bit_d;
   logic                 rx_baud_q, rx_baud_d, rx_done_q, rx_done_d, rx_err_q, rx_err_d;
   logic                 rx_tick, rx_load, rx_s;
   logic [CW-1:0]        rx_load_val;

`ifdef UART_RX_SYNC_EN
   logic [1:0] rx_sync_q, rx_sync_d;
   assign rx_sync_d = {rx_sync_q[0], RxDataIn};
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) rx_sync_q <= 2'b11;
      else        rx_sync_q <= rx_sync_d;
   end
   assign rx_s = rx_sync_q[1];
`else
   assign rx_s = RxDataIn;
`endif

   uart_bit_timer #(.CNT_W_P(CW)) u_tx_timer (
      .clk(Clock), .rst_n(Reset), .en(tx_state_q != TX_IDLE),
      .load(tx_load), .load_val(tx_load_val), .tick(tx_tick)
   );

   uart_bit_timer #(.CNT_W_P(CW)) u_rx_timer (
      .clk(Clock), .rst_n(Reset),
      .en(rx_state_q inside {RX_START, RX_DATA, RX_STOP}),
      .load(rx_load), .load_val(rx_load_val), .tick(rx_tick)
   );

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         tx_state_q <= TX_IDLE;  tx_shift_q <= '0; tx_bit_q <= '0;
         tx_baud_q  <= 1'b0;     tx_out_q   <= 1'b1; tx_done_q <= 1'b0;
         rx_state_q <= RX_IDLE;  rx_shift_q <= '0; rx_data_q <= '0; rx_bit_q <= '0;
         rx_baud_q  <= 1'b0;     rx_done_q  <= 1'b0; rx_err_q <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d; tx_shift_q <= tx_shift_d; tx_bit_q <= tx_bit_d;
         tx_baud_q  <= tx_baud_d;  tx_out_q   <= tx_out_d;   tx_done_q <= tx_done_d;
         rx_state_q <= rx_state_d; rx_shift_q <= rx_shift_d; rx_data_q <= rx_data_d;
         rx_bit_q   <= rx_bit_d;   rx_baud_q  <= rx_baud_d;  rx_done_q <= rx_done_d;
         rx_err_q   <= rx_err_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      case (tx_state_q)
         TX_IDLE:  if (TxDataLoad) tx_state_d = TX_START;
         TX_START: if (tx_tick) tx_state_d = TX_DATA;
         TX_DATA:  if (tx_tick && tx_bit_q == LAST_BIT) tx_state_d = TX_STOP;
         TX_STOP:  if (tx_tick) tx_state_d = TX_IDLE;
         default:  tx_state_d = TX_IDLE;
      endcase
   end

   // Line level is registered from the next state so the start bit appears the cycle after the load.
   always_comb begin
      tx_shift_d = tx_shift_q;
      tx_bit_d   = tx_bit_q;
      tx_baud_d  = tx_baud_q;
      tx_load    = 1'b0;
      if (tx_state_q == TX_IDLE && TxDataLoad) begin
         tx_shift_d = TxDataIn;
         tx_bit_d   = '0;
         tx_baud_d  = BaudRate;
         tx_load    = 1'b1;
      end else if (tx_tick) begin
         tx_load = 1'b1;
         if (tx_state_q == TX_DATA) begin
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 3'd1;
         end
      end
      tx_load_val = tx_baud_d ? FULL1 : FULL0;
      case (tx_state_d)
         TX_START: tx_out_d = 1'b0;
         TX_DATA:  tx_out_d = tx_shift_d[0];
         default:  tx_out_d = 1'b1;
      endcase
      tx_done_d = (tx_state_q == TX_STOP) && tx_tick;
   end

   always_comb begin
      rx_state_d = rx_state_q;
      case (rx_state_q)
         RX_IDLE:      if (!rx_s) rx_state_d = RX_START;
         RX_START:     if (rx_tick) rx_state_d = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:      if (rx_tick && rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
         RX_STOP:      if (rx_tick) rx_state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
         RX_WAIT_HIGH: if (rx_s) rx_state_d = RX_IDLE;
         default:      rx_state_d = RX_IDLE;
      endcase
   end

   // First reload is half a bit so every later tick lands mid-bit.
   always_comb begin
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      rx_bit_d    = rx_bit_q;
      rx_baud_d   = rx_baud_q;
      rx_done_d   = 1'b0;
      rx_err_d    = 1'b0;
      rx_load     = 1'b0;
      rx_load_val = rx_baud_q ? FULL1 : FULL0;
      if (rx_state_q == RX_IDLE && !rx_s) begin
         rx_baud_d   = BaudRate;
         rx_bit_d    = '0;
         rx_load     = 1'b1;
         rx_load_val = BaudRate ? HALF1 : HALF0;
      end else if (rx_tick) begin
         rx_load = 1'b1;
         if (rx_state_q == RX_DATA) begin
            rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
         end
         if (rx_state_q == RX_STOP) begin
            if (rx_s) begin
               rx_data_d = rx_shift_q;
               rx_done_d = 1'b1;
            end else begin
               rx_err_d = 1'b1;
            end
         end
      end
   end

   assign TxDataOut = tx_out_q;
   assign TxDone    = tx_done_q;
   assign RxDataOut = rx_data_q;
   assign RxDone    = rx_done_q;
   assign RxError   = rx_err_q;
endmodule

// File: tb/tb_uart_project.sv
// tb/tb_uart_project.sv - directed self-checking bench for uart_project
module tb_uart_project;
   localparam int C0 = 1042;
   localparam int C1 = 521;
`ifdef UART_RX_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       BaudRate = 1'b0;
   logic       TxDataLoad = 1'b0;
   logic [7:0] TxDataIn = 8'h00;
   logic       RxDataIn = 1'b1;
   logic       TxDataOut, TxDone, RxDone, RxError;
   logic [7:0] RxDataOut;

   int checks = 0;
   int errors = 0;

   always #5 Clock = ~Clock;

   uart_project dut (
      .Clock(Clock), .Reset(Reset), .BaudRate(BaudRate),
      .TxDataLoad(TxDataLoad), .TxDataIn(TxDataIn), .TxDataOut(TxDataOut),
      .RxDataIn(RxDataIn), .RxDataOut(RxDataOut),
      .TxDone(TxDone), .RxDone(RxDone), .RxError(RxError)
   );

   task automatic tx_load(input logic [7:0] b);
      @(negedge Clock);
      TxDataIn   = b;
      TxDataLoad = 1'b1;
   endtask

   // Called right after tx_load; index 0 is the first cycle after the load edge.
   task automatic tx_check(input logic [7:0] b, input int cpb, input logic poke,
                           input logic chain, input logic [7:0] nb, input string nm);
      logic [9:0] frame;
      int         bad [10];
      logic       keep_baud;
      frame     = {1'b1, b, 1'b0};
      keep_baud = BaudRate;
      for (int k = 0; k < 10; k++) bad[k] = 0;
      @(negedge Clock);
      TxDataLoad = 1'b0;
      for (int i = 0; i < 10 * cpb; i++) begin
         if (i > 0) @(negedge Clock);
         if (TxDataOut !== frame[i / cpb] || TxDone !== 1'b0) bad[i / cpb]++;
         if (poke && i == 2 * cpb + 5) begin
            TxDataLoad = 1'b1;
            TxDataIn   = ~b;
            BaudRate   = ~keep_baud;
         end
         if (poke && i == 2 * cpb + 6) TxDataLoad = 1'b0;
      end
      BaudRate = keep_baud;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (bad[k] !== 0) begin
            errors++;
            $display("FAIL %s bit%0d: %0d wrong cycles, required 0 (level %0b)", nm, k, bad[k], frame[k]);
         end
      end
      @(negedge Clock);
      checks++;
      if (TxDone !== 1'b1 || TxDataOut !== 1'b1) begin
         errors++;
         $display("FAIL %s done: TxDone=%b TxDataOut=%b, required 1 1", nm, TxDone, TxDataOut);
      end
      if (chain) begin
         TxDataIn   = nb;
         TxDataLoad = 1'b1;
      end else begin
         @(negedge Clock);
         checks++;
         if (TxDone !== 1'b0) begin
            errors++;
            $display("FAIL %s done_single: TxDone=%b, required 0", nm, TxDone);
         end
      end
   endtask

   // Drives one frame starting at the next falling edge; index i counts falling edges.
   task automatic rx_frame(input logic [7:0] d, input logic stop, input int cpb, input int tail,
                           output int n_done, output int done_at, output int n_err, output int err_at);
      logic [9:0] frame;
      frame   = {stop, d, 1'b0};
      n_done  = 0; n_err = 0; done_at = -1; err_at = -1;
      for (int i = 0; i < 10 * cpb + tail; i++) begin
         @(negedge Clock);
         if (RxDone === 1'b1) begin n_done++; done_at = i; end
         if (RxError === 1'b1) begin n_err++; err_at = i; end
         RxDataIn = (i < 10 * cpb) ? frame[i / cpb] : 1'b1;
      end
   endtask

   task automatic test_reset();
      int pulses = 0;
      Reset = 1'b0;
      repeat (5) @(negedge Clock);
      checks++;
      if (TxDataOut !== 1'b1) begin errors++; $display("FAIL reset_tx_in_reset: got %b, required 1", TxDataOut); end
      Reset = 1'b1;
      repeat (100) begin
         @(negedge Clock);
         if (TxDone !== 1'b0 || RxDone !== 1'b0 || RxError !== 1'b0) pulses++;
      end
      checks++;
      if (TxDataOut !== 1'b1) begin errors++; $display("FAIL reset_tx_idle: got %b, required 1", TxDataOut); end
      checks++;
      if (RxDataOut !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h, required 00", RxDataOut); end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL reset_pulses: got %0d, required 0", pulses); end
   endtask

   task automatic test_tx_baud0();
      BaudRate = 1'b0;
      tx_load(8'h33);
      tx_check(8'h33, C0, 1'b1, 1'b0, 8'h00, "tx33");
   endtask

   task automatic test_rx_good();
      int nd, da, ne, ea;
      BaudRate = 1'b0;
      rx_frame(8'h33, 1'b1, C0, 20, nd, da, ne, ea);
      checks++;
      if (nd !== 1) begin errors++; $display("FAIL rx33_done_count: got %0d, required 1", nd); end
      checks++;
      if (da !== 9 * C0 + C0 / 2 + 1 + SYNC_LAT) begin
         errors++; $display("FAIL rx33_done_time: got %0d, required %0d", da, 9 * C0 + C0 / 2 + 1 + SYNC_LAT);
      end
      checks++;
      if (ne !== 0) begin errors++; $display("FAIL rx33_err_count: got %0d, required 0", ne); end
      checks++;
      if (RxDataOut !== 8'h33) begin errors++; $display("FAIL rx33_data: got %h, required 33", RxDataOut); end
   endtask

   task automatic test_rx_framing_error();
      int nd, da, ne, ea;
      rx_frame(8'hA5, 1'b0, C0, 20, nd, da, ne, ea);
      checks++;
      if (ne !== 1) begin errors++; $display("FAIL rxerr_count: got %0d, required 1", ne); end
      checks++;
      if (ea !== 9 * C0 + C0 / 2 + 1 + SYNC_LAT) begin
         errors++; $display("FAIL rxerr_time: got %0d, required %0d", ea, 9 * C0 + C0 / 2 + 1 + SYNC_LAT);
      end
      checks++;
      if (nd !== 0) begin errors++; $display("FAIL rxerr_done: got %0d, required 0", nd); end
      checks++;
      if (RxDataOut !== 8'h33) begin errors++; $display("FAIL rxerr_data_kept: got %h, required 33", RxDataOut); end
   endtask

   task automatic test_false_start();
      int pulses = 0;
      int nd, da, ne, ea;
      @(negedge Clock);
      RxDataIn = 1'b0;
      repeat (2) @(negedge Clock);
      RxDataIn = 1'b1;
      repeat (C0) begin
         @(negedge Clock);
         if (RxDone !== 1'b0 || RxError !== 1'b0) pulses++;
      end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL false_start_pulses: got %0d, required 0", pulses); end
      BaudRate = 1'b1;
      rx_frame(8'h3C, 1'b1, C1, 20, nd, da, ne, ea);
      checks++;
      if (nd !== 1 || da !== 9 * C1 + C1 / 2 + 1 + SYNC_LAT || ne !== 0) begin
         errors++; $display("FAIL false_start_recover: done=%0d at %0d err=%0d, required 1 at %0d err 0",
                            nd, da, ne, 9 * C1 + C1 / 2 + 1 + SYNC_LAT);
      end
      checks++;
      if (RxDataOut !== 8'h3C) begin errors++; $display("FAIL false_start_data: got %h, required 3c", RxDataOut); end
   endtask

   task automatic test_concurrent();
      int nd, da, ne, ea;
      BaudRate = 1'b1;
      fork
         begin
            tx_load(8'h55);
            tx_check(8'h55, C1, 1'b0, 1'b0, 8'h00, "tx55");
         end
         rx_frame(8'hC3, 1'b1, C1, 20, nd, da, ne, ea);
      join
      checks++;
      if (nd !== 1 || ne !== 0) begin errors++; $display("FAIL rxC3_pulses: done=%0d err=%0d, required 1 0", nd, ne); end
      checks++;
      if (RxDataOut !== 8'hC3) begin errors++; $display("FAIL rxC3_data: got %h, required c3", RxDataOut); end
   endtask

   task automatic test_back_to_back();
      int nd, da, ne, ea;
      BaudRate = 1'b1;
      tx_load(8'hA5);
      tx_check(8'hA5, C1, 1'b0, 1'b1, 8'h3C, "b2b_txA5");
      tx_check(8'h3C, C1, 1'b0, 1'b0, 8'h00, "b2b_tx3C");
      rx_frame(8'h5A, 1'b1, C1, 0, nd, da, ne, ea);
      checks++;
      if (nd !== 1 || RxDataOut !== 8'h5A) begin
         errors++; $display("FAIL b2b_rx5A: done=%0d data=%h, required 1 5a", nd, RxDataOut);
      end
      rx_frame(8'h96, 1'b1, C1, 20, nd, da, ne, ea);
      checks++;
      if (nd !== 1 || da !== 9 * C1 + C1 / 2 + 1 + SYNC_LAT || RxDataOut !== 8'h96) begin
         errors++; $display("FAIL b2b_rx96: done=%0d at %0d data=%h, required 1 at %0d 96",
                            nd, da, RxDataOut, 9 * C1 + C1 / 2 + 1 + SYNC_LAT);
      end
   endtask

   task automatic test_reset_mid_tx();
      int bad = 0;
      BaudRate = 1'b1;
      tx_load(8'h00);
      @(negedge Clock);
      TxDataLoad = 1'b0;
      repeat (3 * C1) @(negedge Clock);
      checks++;
      if (TxDataOut !== 1'b0) begin errors++; $display("FAIL midtx_level: got %b, required 0", TxDataOut); end
      #1 Reset = 1'b0;
      #1;
      checks++;
      if (TxDataOut !== 1'b1) begin errors++; $display("FAIL midtx_reset_tx: got %b, required 1", TxDataOut); end
      checks++;
      if (RxDataOut !== 8'h00) begin errors++; $display("FAIL midtx_reset_rx: got %h, required 00", RxDataOut); end
      @(negedge Clock);
      Reset = 1'b1;
      repeat (8 * C1) begin
         @(negedge Clock);
         if (TxDataOut !== 1'b1 || TxDone !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL midtx_after_reset: %0d bad cycles, required 0", bad); end
   endtask

   initial begin
      test_reset();
      test_tx_baud0();
      test_rx_good();
      test_rx_framing_error();
      test_false_start();
      test_concurrent();
      test_back_to_back();
      test_reset_mid_tx();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
